bus_master: RTL
===============

# bus_master

Transaction controller that sits directly upstream of the bidirectional-bus peripheral stage, which holds the address decoder. It accepts read/write requests on a valid/ready interface and drives the peripheral's `addr` and `sel` inputs. It also shares the 8-bit tri-state `data_bus` with that stage.
- On writes it drives `data_bus`.
- On reads it asserts `sel` so the peripheral drives the bus, waits out the decode latency, captures the data and returns it on a one-cycle response strobe.

## Interface
Parameters:
- `DATA_W`, 8, bus data width; must match the peripheral.
- `ADDR_W`, 8, address width.
- `WAIT_CYCLES`, 1, number of cycles `sel` is held before read data is sampled; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  `ADDR_W`  target address.
- `req_wdata`  in  `DATA_W`  write data.
- `rsp_valid`  out  1  one-cycle strobe: read data valid.
- `rsp_rdata`  out  `DATA_W`  captured read data; holds its value until the next capture.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `addr`  out  `ADDR_W`  address to the peripheral.
- `sel`  out  1  1 = peripheral drives `data_bus`.
- `data_bus`  inout  `DATA_W`  shared tri-state bus.

## Operation
FSM states: IDLE, WRITE, READ, TURN.
- **IDLE**
  - `req_ready`=1.
  - A handshake (`req_valid`&`req_ready`) latches `req_write`, `req_addr` and `req_wdata` into internal registers.
  - Next state is WRITE if `req_write`=1, otherwise READ.
- **WRITE** (exactly 1 cycle)
  - `addr` = latched address, `sel`=0.
  - The master output enable is 1, so `data_bus` = latched wdata.
  - Next state: TURN.
- **READ** (exactly `WAIT_CYCLES` cycles)
  - `addr` = latched address, `sel`=1, master output enable 0.
  - The wait counter loads `WAIT_CYCLES`-1 on entry and decrements each cycle.
  - On the cycle the counter is 0, `data_bus` is registered into `rsp_rdata` and the next state is TURN.
  - `rsp_valid` is a registered pulse, high for the one cycle following the capture.
- **TURN** (exactly 1 cycle)
  - `sel`=0 and master output enable 0, so the bus floats.
  - `addr` holds its last value.
  - Next state: IDLE.
- The master output enable and `sel` are never both 1. This is enforced by state decode, not by timing.
- Every transaction ends in TURN, so a direction change can never cause bus contention.
- `req_*` inputs are sampled only at the handshake. Changes at any other time are ignored.
- `req_ready` = (state==IDLE), combinational from the state register.
- `busy` = !`req_ready`.
- Any value on `data_bus` at capture, including X/Z, is captured as-is; it is not checked.

## Timing
Reset values, all applied asynchronously on `rst`=0:
- state = IDLE, `addr`=0, `sel`=0, master output enable 0 (`data_bus` released immediately), `rsp_valid`=0, `rsp_rdata`=0, counter=0.
- `req_ready` is 1 during and after reset. Requests presented while `rst`=0 are not accepted.

Latency, with the handshake in cycle T:
- Write: WRITE in T+1, TURN in T+2, `req_ready` high again in T+3. Throughput is one write per 3 cycles.
- Read: READ in T+1..T+`WAIT_CYCLES`, capture at the end of T+`WAIT_CYCLES`.
  - `rsp_valid` and the new `rsp_rdata` appear in T+`WAIT_CYCLES`+1, which is the TURN cycle.
  - `req_ready` is high in T+`WAIT_CYCLES`+2.

Boundary conditions:
- **Back-to-back requests:** `req_valid` held high continuously is accepted at each IDLE; there are no extra idle cycles beyond TURN.
- **Reset mid-READ:** `rsp_valid` is never asserted for the aborted read.
- **Reset mid-WRITE:** the bus is released within the reset assertion, with no clock edge needed.
- **Counter width:** 4 bits. Values of `WAIT_CYCLES` outside 1..15 are rejected by an elaboration-time check.

## Structure
- Shared package `bus_pkg`:
  - state enum (IDLE/WRITE/READ/TURN);
  - `BUS_DATA_W`=8 and `BUS_ADDR_W`=8, which the peripheral stage uses too;
  - command constants `CMD_READ`=0 and `CMD_WRITE`=1.
- No sub-module. FSM, wait counter and capture register are inline. The tri-state driver is a single continuous assignment gated by the output enable.
- The bench instantiates `bus_master` together with the peripheral stage on a shared `data_bus` net.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles while `req_valid`=1. Required: `sel`=0, `addr`=0, `data_bus`=Z, no handshake. After release, the handshake occurs on the first edge.
- **Write:** write addr 0x12, data 0xA5 with `WAIT_CYCLES`=1. Required: in T+1 `data_bus`=0xA5, `addr`=0x12, `sel`=0; in T+2 the bus is Z; `req_ready`=1 in T+3.
- **Read:** read addr 0x34, peripheral returning 0x5C, `WAIT_CYCLES`=2. Required: `sel`=1 in T+1..T+2; `rsp_valid`=1 for exactly one cycle in T+3 with `rsp_rdata`=0x5C.
- **Direction change:** write 0x01, then read, then write, with `req_valid` held high. Required: every cycle has output enable and `sel` not both 1, and there is exactly one TURN cycle between transactions.
- **Reset mid-READ:** assert `rst` in T+1 of a read with `WAIT_CYCLES`=3. Required: `sel` drops to 0 without a clock edge, `rsp_valid` never asserts, and `rsp_rdata`=0.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared widths, command codes and FSM states for the bidirectional bus stage
package bus_pkg;
  localparam int BUS_DATA_W = 8;
  localparam int BUS_ADDR_W = 8;
  localparam logic CMD_READ = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;
endpackage

// File: rtl/bus_master.sv
// bus_master: valid/ready request controller driving addr/sel and a shared tri-state data bus
module bus_master
  import bus_pkg::*;
#(
  parameter int DATA_W = BUS_DATA_W,
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              sel,
  inout  wire  [DATA_W-1:0] data_bus
);
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("bus_master: WAIT_CYCLES must be within 1..15");
  end
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
  state_t state, state_d;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0] cnt;
  logic hs, oe, last;
  assign req_ready = state == IDLE;
  assign busy = !req_ready;
  assign hs = req_valid & req_ready;
  assign sel = state == READ;
  assign oe = state == WRITE;
  assign last = sel && cnt == 4'd0;
  assign data_bus = oe ? wdata_q : 'z;
  // state register; reset returns to IDLE immediately so sel and oe drop without a clock
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;
  // next state: every transaction passes through TURN before IDLE
  always_comb begin
    state_d = state;
    state_d = state == IDLE  ? (hs ? (req_write == CMD_WRITE ? WRITE : READ) : IDLE) :
              state == WRITE ? TURN :
              state == READ  ? (last ? TURN : READ) : IDLE;
  end
  // request latch, read wait counter and capture register with its response strobe
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr <= '0;
      wdata_q <= '0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= last;
      if (hs) begin
        addr <= req_addr;
        wdata_q <= req_wdata;
        cnt <= CNT_LOAD;
      end else if (sel && !last) cnt <= cnt - 4'd1;
      if (last) rsp_rdata <= data_bus;
    end
endmodule
